// File: rtl/nvram_ioctl.sv
// Bridge between the hps_io ioctl channel and the 1024 x 4-bit CMOS RAM: NVRAM download/upload plus CPU arbitration.
// Define NVRAM_UPLOAD_EN to build the upload path; without it only downloads touch the RAM.
module nvram_ioctl #(
   parameter int          ADDR_W   = 10,
   parameter logic [15:0] NV_INDEX = 16'd4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_upload,
   input  logic              ioctl_wr,
   input  logic              ioctl_rd,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [15:0]       ioctl_index,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_we,
   input  logic [3:0]        cpu_din,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [3:0]        ram_d,
   input  logic [3:0]        ram_q,
   output logic              pause_req,
   output logic              nv_dirty
);

`ifdef NVRAM_UPLOAD_EN
   typedef enum logic [2:0] {IDLE, DN_WR, UP_ADDR, UP_LAT, UP_CAP} state_t;
`else
   typedef enum logic {IDLE, DN_WR} state_t;
`endif

   state_t            state_q, state_d;
   logic              own_q, own_d;
   logic              wr_pend_q, wr_pend_d;
   logic              in_range_q, in_range_d;
   logic              acc_q, acc_d;
   logic              dirty_q, dirty_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        data_q, data_d;

   logic              active, go, wr_strobe, any_strobe, fsm_we;

`ifdef NVRAM_UPLOAD_EN
   logic              rd_pend_q, rd_pend_d;
   logic [7:0]        din_q, din_d;
   logic              rd_strobe;
   logic              unused_ok;

   assign rd_strobe  = active & ioctl_upload & ioctl_rd;
   assign any_strobe = wr_strobe | rd_strobe;
   assign unused_ok  = &{1'b0, ioctl_dout[7:4]};
`else
   logic              unused_ok;

   assign any_strobe = wr_strobe;
   assign unused_ok  = &{1'b0, ioctl_rd, ram_q, ioctl_dout[7:4]};
`endif

   assign active    = (ioctl_download | ioctl_upload) & (ioctl_index == NV_INDEX);
   assign wr_strobe = active & ioctl_wr;
   // Accesses start only while the transfer is still live, so a pending strobe dies with own.
   assign go        = own_q & active;

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      wr_pend_d  = wr_pend_q;
      in_range_d = in_range_q;
      addr_d     = addr_q;
      data_d     = data_q;
      acc_d      = acc_q;
      dirty_d    = dirty_q;
      fsm_we     = 1'b0;
`ifdef NVRAM_UPLOAD_EN
      rd_pend_d  = rd_pend_q;
      din_d      = din_q;
`endif
      // An in-flight access keeps ownership until it has finished.
      own_d      = active | (own_q & (state_q != IDLE));

      if (any_strobe) begin
         addr_d     = ioctl_addr[ADDR_W-1:0];
         in_range_d = (ioctl_addr[24:ADDR_W] == '0);
         data_d     = ioctl_dout[3:0];
         wr_pend_d  = wr_strobe;
`ifdef NVRAM_UPLOAD_EN
         rd_pend_d  = rd_strobe;
`endif
      end

      case (state_q)
         IDLE: begin
            if (go) begin
               if (wr_strobe) begin
                  state_d   = DN_WR;
                  wr_pend_d = 1'b0;
`ifdef NVRAM_UPLOAD_EN
                  rd_pend_d = 1'b0;
               end else if (rd_strobe) begin
                  state_d   = UP_ADDR;
                  wr_pend_d = 1'b0;
                  rd_pend_d = 1'b0;
`endif
               end else if (wr_pend_q) begin
                  state_d   = DN_WR;
                  wr_pend_d = 1'b0;
`ifdef NVRAM_UPLOAD_EN
               end else if (rd_pend_q) begin
                  state_d   = UP_ADDR;
                  rd_pend_d = 1'b0;
`endif
               end
            end
         end
         DN_WR: begin
            fsm_we  = in_range_q;
            acc_d   = acc_q | in_range_q;
            state_d = IDLE;
         end
`ifdef NVRAM_UPLOAD_EN
         UP_ADDR: state_d = UP_LAT;
         UP_LAT: begin
            // ram_q now holds the word addressed during UP_ADDR.
            din_d   = in_range_q ? {4'h0, ram_q} : 8'h00;
            acc_d   = acc_q | in_range_q;
            state_d = UP_CAP;
         end
         UP_CAP:  state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase

      if (cpu_we & ~own_q) begin
         dirty_d = 1'b1;
      end

      if (own_q & ~own_d) begin
         wr_pend_d = 1'b0;
`ifdef NVRAM_UPLOAD_EN
         rd_pend_d = 1'b0;
`endif
         acc_d     = 1'b0;
         if (acc_q) begin
            dirty_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         own_q      <= 1'b0;
         wr_pend_q  <= 1'b0;
         in_range_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= 4'h0;
         acc_q      <= 1'b0;
         dirty_q    <= 1'b0;
`ifdef NVRAM_UPLOAD_EN
         rd_pend_q  <= 1'b0;
         din_q      <= 8'h00;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q    <= state_d;
         own_q      <= own_d;
         wr_pend_q  <= wr_pend_d;
         in_range_q <= in_range_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         acc_q      <= acc_d;
         dirty_q    <= dirty_d;
`ifdef NVRAM_UPLOAD_EN
         rd_pend_q  <= rd_pend_d;
         din_q      <= din_d;
`endif
      end
   end

   assign ram_addr  = own_q ? addr_q : cpu_addr;
   assign ram_we    = own_q ? fsm_we : cpu_we;
   assign ram_d     = own_q ? data_q : cpu_din;
   assign pause_req = own_q;
   assign nv_dirty  = dirty_q;

`ifdef NVRAM_UPLOAD_EN
   assign ioctl_din  = din_q;
   assign ioctl_wait = rd_strobe | rd_pend_q | (state_q == UP_ADDR) | (state_q == UP_LAT);
`else
   assign ioctl_din  = 8'h00;
   assign ioctl_wait = 1'b0;
`endif

endmodule
